// File: rtl/sonar_pkg.sv
// sonar_pkg: shared states and constants for the sonar channel blocks
package sonar_pkg;
    localparam int SONAR_N  = 16;
    localparam int SONAR_CW = 16;
    // Wide all-ones value, cast down to the counter width where it is used.
    localparam logic [63:0] TOF_NONE = '1;
    typedef enum logic [1:0] {IDLE, BLANK, LISTEN, DONE} state_e;
endpackage

// File: rtl/echo_mag_abs.sv
// echo_mag_abs: saturating magnitude |x| of a signed sample
// Ports: x - N-bit signed sample; mag - N-1-bit unsigned magnitude, most negative input clips to all ones.
module echo_mag_abs
    import sonar_pkg::*;
#(
    parameter int N = SONAR_N
) (
    input  logic signed [N-1:0] x,
    output logic        [N-2:0] mag
);
    logic [N-1:0] neg;
    always_comb begin
        neg = -x;
        // Only -2^(N-1) still has its top bit set after negation.
        mag = !x[N-1] ? x[N-2:0] : neg[N-1] ? '1 : neg[N-2:0];
    end
endmodule

// File: rtl/echo_detector.sv
// echo_detector: first-echo time-of-flight detector on the filtered sample stream
// Build macro ECHO_DETECTOR_PEAK_EN adds a peak-magnitude tracker over the listen window.
// Ports: clk, rst (async active high); en/X sample strobe and signed sample; start launches
// a ping measurement; thresh/blank_len/timeout configure it; busy, detect, tof, irq and
// peak report the measurement to the register/IRQ block.
module echo_detector
    import sonar_pkg::*;
#(
    parameter int N    = SONAR_N,
    parameter int CW   = SONAR_CW,
    parameter int HOLD = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic signed [N-1:0] X,
    input  logic                start,
    input  logic        [N-2:0] thresh,
    input  logic       [CW-1:0] blank_len,
    input  logic       [CW-1:0] timeout,
    output logic                busy,
    output logic                detect,
    output logic       [CW-1:0] tof,
    output logic                irq,
    output logic        [N-2:0] peak
);
    localparam int RW = 4;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, first_q, first_d, tof_q, tof_d;
    logic [RW-1:0] run_q, run_d, run_inc;
    logic          detect_q, detect_d, above;
    logic  [N-2:0] mag;

    echo_mag_abs #(.N(N)) u_mag (.x(X), .mag(mag));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        run_d    = run_q;
        first_d  = first_q;
        detect_d = detect_q;
        tof_d    = tof_q;
        above    = mag > thresh;
        run_inc  = run_q + RW'(1);
        case (state_q)
            IDLE: if (start) begin
                state_d  = (blank_len == '0) ? LISTEN : BLANK;
                cnt_d    = '0;
                run_d    = '0;
                detect_d = 1'b0;
                tof_d    = '0;
            end
            BLANK: if (en) begin
                cnt_d   = cnt_q + CW'(1);
                state_d = (cnt_q == blank_len - CW'(1)) ? LISTEN : BLANK;
            end
            LISTEN: if (en) begin
                cnt_d   = cnt_q + CW'(1);
                run_d   = above ? run_inc : '0;
                first_d = (above && run_q == '0) ? cnt_q : first_q;
                // A run finishing on the last window sample still counts as a detection.
                if (above && run_inc == RW'(HOLD)) begin
                    state_d  = DONE;
                    detect_d = 1'b1;
                    tof_d    = (run_q == '0) ? cnt_q : first_q;
                end else if (cnt_q == timeout - CW'(1)) begin
                    state_d = DONE;
                    tof_d   = CW'(TOF_NONE);
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            run_q    <= '0;
            first_q  <= '0;
            detect_q <= 1'b0;
            tof_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            run_q    <= run_d;
            first_q  <= first_d;
            detect_q <= detect_d;
            tof_q    <= tof_d;
        end
    end

    assign busy   = (state_q == BLANK) || (state_q == LISTEN);
    assign irq    = state_q == DONE;
    assign detect = detect_q;
    assign tof    = tof_q;

`ifdef ECHO_DETECTOR_PEAK_EN
    logic [N-2:0] peak_q, peak_d;
    always_comb begin
        peak_d = (state_q == IDLE && start) ? '0 :
                 (state_q == LISTEN && en && mag > peak_q) ? mag : peak_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) peak_q <= '0;
        else     peak_q <= peak_d;
    end
    assign peak = peak_q;
`else
    assign peak = '0;
`endif
endmodule

// File: tb/tb_echo_detector.sv
// tb_echo_detector: self-checking bench for echo_detector
module tb_echo_detector;
    localparam int N = 16, CW = 16, HOLD = 3;

    logic                clk = 0, rst = 0, en = 0, start = 0;
    logic signed [N-1:0] X = '0;
    logic        [N-2:0] thresh = '0;
    logic       [CW-1:0] blank_len = '0, timeout = '0;
    logic                busy, detect, irq;
    logic       [CW-1:0] tof;
    logic        [N-2:0] peak;

    int n_cmp = 0, n_fail = 0;
    int samp[256];
    int thr, bl, to;

    typedef struct {
        int thr, bl, to, gap, misc, base;
        int a0, l0, v0, a1, l1, v1;
        int det, tof, last, pk;
    } vec_t;
    vec_t tbl[9];

    echo_detector #(.N(N), .CW(CW), .HOLD(HOLD)) dut (
        .clk(clk), .rst(rst), .en(en), .X(X), .start(start), .thresh(thresh),
        .blank_len(blank_len), .timeout(timeout), .busy(busy), .detect(detect),
        .tof(tof), .irq(irq), .peak(peak)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic int mag_of(input int v);
        int m = (v < 0) ? -v : v;
        return (m > 32767) ? 32767 : m;
    endfunction

    // Reference: scan the listen window sample by sample and apply the echo rules.
    function automatic void model(output int det, output int etof, output int last, output int pk);
        int run = 0, first = 0;
        det = 0; etof = 65535; last = to - 1; pk = 0;
        for (int i = bl; i < to; i++) begin
            int m = mag_of(samp[i]);
            if (m > pk) pk = m;
            if (m > thr) begin
                if (run == 0) first = i;
                run++;
                if (run == HOLD) begin
                    det = 1; etof = first; last = i;
                    return;
                end
            end else run = 0;
        end
    endfunction

    // misc bit0: extra start pulses while busy and during DONE; bit1: en coincident with start.
    task automatic measure(input string nm, input int gap, input int misc,
                           input int e_det, input int e_tof, input int e_last, input int e_pk);
        int pk;
`ifdef ECHO_DETECTOR_PEAK_EN
        pk = e_pk;
`else
        pk = 0;
`endif
        thresh = (N-1)'(thr); blank_len = CW'(bl); timeout = CW'(to);
        @(posedge clk); #1;
        start = 1;
        if (misc[1]) begin en = 1; X = 16'sh7fff; end
        @(posedge clk); #1;
        start = 0; en = 0;
        chk({nm, " start busy"}, int'(busy), 1);
        chk({nm, " start detect"}, int'(detect), 0);
        chk({nm, " start tof"}, int'(tof), 0);
        for (int i = 0; i <= e_last; i++) begin
            repeat (gap - 1) begin @(posedge clk); #1; end
            X = N'(samp[i]); en = 1;
            if (misc[0] && i == 1) start = 1;
            @(posedge clk); #1;
            en = 0; start = 0;
            if (i < e_last) chk($sformatf("%s idx%0d irq,busy", nm, i), int'({irq, busy}), 1);
        end
        chk({nm, " end irq,busy"}, int'({irq, busy}), 2);
        chk({nm, " detect"}, int'(detect), e_det);
        chk({nm, " tof"}, int'(tof), e_tof);
        chk({nm, " peak"}, int'(peak), pk);
        if (misc[0]) start = 1;
        @(posedge clk); #1;
        start = 0;
        chk({nm, " post irq,busy"}, int'({irq, busy}), 0);
        chk({nm, " hold detect"}, int'(detect), e_det);
        chk({nm, " hold tof"}, int'(tof), e_tof);
    endtask

    task automatic run_vec(input int t);
        for (int i = 0; i < 256; i++) samp[i] = tbl[t].base;
        for (int j = 0; j < tbl[t].l0; j++) samp[tbl[t].a0 + j] = tbl[t].v0;
        for (int j = 0; j < tbl[t].l1; j++) samp[tbl[t].a1 + j] = tbl[t].v1;
        thr = tbl[t].thr; bl = tbl[t].bl; to = tbl[t].to;
        measure($sformatf("vec%0d", t), tbl[t].gap, tbl[t].misc,
                tbl[t].det, tbl[t].tof, tbl[t].last, tbl[t].pk);
    endtask

    initial begin
        int e_det, e_tof, e_last, e_pk, gap, misc, r, v;
        tbl[0] = '{1000, 4, 100, 11, 0, 0,    0, 3, 32767,  10, 3, 32767, 1, 10,    12, 32767};
        tbl[1] = '{1000, 4, 100, 11, 0, 500,  10, 2, 2000,  13, 3, -2000, 1, 13,    15, 2000};
        tbl[2] = '{32766, 0, 100, 11, 2, 0,   5, 3, -32768, 0, 0, 0,      1, 5,     7,  32767};
        tbl[3] = '{1000, 4, 50, 11, 0, 0,     0, 0, 0,      0, 0, 0,      0, 65535, 49, 0};
        tbl[4] = '{1000, 4, 20, 3, 0, 0,      17, 3, -5000, 0, 0, 0,      1, 17,    19, 5000};
        tbl[5] = '{1000, 4, 30, 3, 0, 0,      10, 2, 3000,  0, 0, 0,      0, 65535, 29, 3000};
        tbl[6] = '{1000, 2, 40, 3, 0, 1000,   12, 3, 1001,  0, 0, 0,      1, 12,    14, 1001};
        tbl[7] = '{1000, 4, 100, 1, 1, 0,     0, 3, 32767,  10, 3, 32767, 1, 10,    12, 32767};
        tbl[8] = '{1000, 4, 100, 2, 0, 0,     2, 4, 32767,  8, 3, 32767,  1, 8,     10, 32767};

        #1 rst = 1;
        #2;
        chk("reset busy", int'(busy), 0);
        chk("reset irq", int'(irq), 0);
        chk("reset detect", int'(detect), 0);
        chk("reset tof", int'(tof), 0);
        chk("reset peak", int'(peak), 0);
        repeat (2) @(posedge clk);
        #1 rst = 0;
        X = 16'sh7fff; en = 1;
        @(posedge clk); #1 en = 0;
        chk("idle en ignored", int'({irq, busy}), 0);

        for (int t = 0; t < 9; t++) run_vec(t);

        for (int s = 0; s < 30; s++) begin
            thr = $urandom_range(50, 30000);
            bl = $urandom_range(0, 8);
            to = bl + 1 + $urandom_range(0, 50);
            for (int i = 0; i < 256; i++) begin
                r = $urandom_range(0, 3);
                v = (r == 0) ? int'($urandom_range(0, 65535)) - 32768 :
                    (r == 1) ? int'($urandom_range(thr + 1, 32767)) : int'($urandom_range(0, thr));
                samp[i] = (r != 0 && $urandom_range(0, 1) == 1) ? -v : v;
            end
            gap = $urandom_range(1, 3);
            misc = $urandom_range(0, 3);
            model(e_det, e_tof, e_last, e_pk);
            measure($sformatf("rnd%0d", s), gap, misc, e_det, e_tof, e_last, e_pk);
        end

        run_vec(0);
        #3 rst = 1;
        #1;
        chk("async rst detect", int'(detect), 0);
        chk("async rst tof", int'(tof), 0);
        chk("async rst peak", int'(peak), 0);
        @(posedge clk); #1 rst = 0;

        thresh = 15'd1000; blank_len = 16'd2; timeout = 16'd100;
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            X = (i < 2) ? 16'sd0 : 16'sh7fff; en = 1;
            @(posedge clk); #1 en = 0;
        end
        chk("mid listen busy", int'(busy), 1);
        #2 rst = 1;
        #1;
        chk("async rst busy", int'({irq, busy}), 0);
        @(posedge clk); #1 rst = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            X = 16'sh7fff; en = 1;
            @(posedge clk); #1 en = 0;
            chk($sformatf("post rst idle%0d", i), int'({irq, busy, detect}), 0);
        end
        run_vec(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
